// File: rtl/bias_pkg.sv
// Shared types and helpers for the bias bank loader.
package bias_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } bias_state_e;

  localparam logic MODE_BANK_MAJOR = 1'b0;
  localparam logic MODE_WORD_MAJOR = 1'b1;

  // Bits needed to index 'value' items; never less than one.
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/bias_beat_sequencer.sv
// Tracks bank/word position of each popped beat and its target buffer address.
module bias_beat_sequencer
  import bias_pkg::*;
#(
  parameter int unsigned ADDR_LEN   = 16,
  parameter int unsigned SINGLE_LEN = 24,
  parameter int unsigned BANK_NUM   = 2,
  localparam int unsigned BANK_W    = clogb2(BANK_NUM)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  step,
  input  logic                  mode_in,
  input  logic [SINGLE_LEN-1:0] bias_num_in,
  input  logic [ADDR_LEN-1:0]   stride_in,
  input  logic [ADDR_LEN-1:0]   st_addr_in,
  output logic [BANK_W-1:0]     bank,
  output logic [ADDR_LEN-1:0]   addr,
  output logic                  last_c
);

  logic                  mode_q;
  logic [SINGLE_LEN-1:0] bias_num_q;
  logic [ADDR_LEN-1:0]   stride_q;
  logic [ADDR_LEN-1:0]   base_q;
  logic [SINGLE_LEN-1:0] word;
  logic                  bank_last;
  logic                  word_last;

  assign bank_last = (bank == BANK_W'(BANK_NUM - 1));
  assign word_last = (word == bias_num_q - SINGLE_LEN'(1));
  assign last_c    = bank_last && word_last;

  // addr always equals base + word*stride; it steps by stride whenever word does.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q     <= MODE_BANK_MAJOR;
      bias_num_q <= '0;
      stride_q   <= '0;
      base_q     <= '0;
      word       <= '0;
      bank       <= '0;
      addr       <= '0;
    end else if (load) begin
      mode_q     <= mode_in;
      bias_num_q <= bias_num_in;
      stride_q   <= stride_in;
      base_q     <= st_addr_in;
      word       <= '0;
      bank       <= '0;
      addr       <= st_addr_in;
    end else if (step) begin
      if (mode_q == MODE_BANK_MAJOR) begin
        if (word_last) begin
          word <= '0;
          addr <= base_q;
          bank <= bank_last ? '0 : bank + BANK_W'(1);
        end else begin
          word <= word + SINGLE_LEN'(1);
          addr <= addr + stride_q;
        end
      end else begin
        if (bank_last) begin
          bank <= '0;
          word <= word + SINGLE_LEN'(1);
          addr <= addr + stride_q;
        end else begin
          bank <= bank + BANK_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/bias_bank_loader.sv
// Loads one bias job from DDR: issues the read request, then scatters FIFO
// beats across the bias banks and pulses done on the final write.
module bias_bank_loader
  import bias_pkg::*;
#(
  parameter int unsigned X_PE         = 16,
  parameter int unsigned DDR_ADDR_LEN = 32,
  parameter int unsigned ADDR_LEN     = 16,
  parameter int unsigned DATA_LEN     = 64,
  parameter int unsigned SINGLE_LEN   = 24,
  parameter int unsigned BANK_NUM     = 8 * X_PE / DATA_LEN
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    conf,
  input  logic                    mode,
  input  logic [SINGLE_LEN-1:0]   bias_num,
  input  logic [ADDR_LEN-1:0]     bb_stride,
  input  logic [DDR_ADDR_LEN-1:0] ddr_st_addr,
  input  logic [ADDR_LEN-1:0]     bb_st_addr,
  input  logic                    abort,
  output logic [DDR_ADDR_LEN-1:0] ddr_st_addr_out,
  output logic [SINGLE_LEN-1:0]   ddr_len,
  output logic                    ddr_conf,
  input  logic                    ddr_fifo_empty,
  input  logic [DATA_LEN-1:0]     ddr_fifo_data,
  output logic                    ddr_fifo_req,
  output logic [ADDR_LEN-1:0]     bb_addr,
  output logic [DATA_LEN-1:0]     bb_data,
  output logic [BANK_NUM-1:0]     bb_wea,
  output logic                    idle,
  output logic                    done,
  output logic                    conf_err
);

  localparam int unsigned BANK_W     = clogb2(BANK_NUM);
  localparam int unsigned WORD_BYTES = BANK_NUM * (DATA_LEN / 8);

  bias_state_e         state;
  logic                load;
  logic                pop;
  logic [BANK_W-1:0]   seq_bank;
  logic [ADDR_LEN-1:0] seq_addr;
  logic                seq_last_c;

  assign load         = (state == S_IDLE) && conf;
  assign pop          = (state == S_STREAM) && !ddr_fifo_empty;
  assign ddr_fifo_req = pop;

  bias_beat_sequencer #(
    .ADDR_LEN   (ADDR_LEN),
    .SINGLE_LEN (SINGLE_LEN),
    .BANK_NUM   (BANK_NUM)
  ) u_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .step       (pop),
    .mode_in    (mode),
    .bias_num_in(bias_num),
    .stride_in  (bb_stride),
    .st_addr_in (bb_st_addr),
    .bank       (seq_bank),
    .addr       (seq_addr),
    .last_c     (seq_last_c)
  );

  // Control FSM plus the DDR request and bank write-port registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      ddr_st_addr_out <= '0;
      ddr_len         <= '0;
      ddr_conf        <= 1'b0;
      bb_addr         <= '0;
      bb_data         <= '0;
      bb_wea          <= '0;
      idle            <= 1'b1;
      done            <= 1'b0;
      conf_err        <= 1'b0;
    end else begin
      ddr_conf <= 1'b0;
      done     <= 1'b0;
      bb_wea   <= '0;

      if (conf && (state != S_IDLE)) conf_err <= 1'b1;

      // A pop always lands as a write, even in an aborting cycle.
      if (pop) begin
        bb_wea  <= BANK_NUM'(1) << seq_bank;
        bb_addr <= seq_addr;
        bb_data <= ddr_fifo_data;
      end

      case (state)
        S_IDLE: begin
          if (conf) begin
            conf_err        <= 1'b0;
            idle            <= 1'b0;
            ddr_st_addr_out <= ddr_st_addr;
            ddr_len         <= bias_num * SINGLE_LEN'(WORD_BYTES);
            if (bias_num == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state    <= S_REQ;
              ddr_conf <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (abort) begin
            state <= S_IDLE;
            idle  <= 1'b1;
          end else begin
            state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (abort) begin
            state <= S_IDLE;
            idle  <= 1'b1;
          end else if (pop && seq_last_c) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          idle  <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          idle  <= 1'b1;
        end
      endcase
    end
  end

endmodule
